// File: rtl/regfile_scoreboard_pkg.sv
// Shared register-file defaults and the address-width helper, also imported by
// the hazard unit and EX forwarding.
package rf_pkg;

  localparam int unsigned XLEN_DEF  = 32;
  localparam int unsigned NREGS_DEF = 32;
  localparam int unsigned CW_DEF    = 2;
  localparam int unsigned ZERO_REG  = 0;

  function automatic int unsigned rf_aw(input int unsigned nregs);
    return (nregs <= 1) ? 1 : $clog2(nregs);
  endfunction

endpackage

// File: rtl/regfile_scoreboard_if.sv
// ID/WB/squash bus of the register file with scoreboard; master drives requests.
interface regfile_scoreboard_if
  import rf_pkg::*;
#(
  parameter int unsigned XLEN  = XLEN_DEF,
  parameter int unsigned NREGS = NREGS_DEF,
  parameter int unsigned NRD   = 2,
  parameter int unsigned NKILL = 2,
  parameter int unsigned AW    = rf_aw(NREGS)
) ();

  logic [NRD*AW-1:0]   rd_num;
  logic [NRD-1:0]      rd_use;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_busy;
  logic                stall;
  logic                issue_valid;
  logic [AW-1:0]       issue_reg;
  logic                issue_ready;
  logic                wb_valid;
  logic [AW-1:0]       wb_reg;
  logic [XLEN-1:0]     wb_data;
  logic [NKILL-1:0]    kill_valid;
  logic [NKILL*AW-1:0] kill_reg;
  logic                err;

  modport master (
    output rd_num, rd_use, issue_valid, issue_reg, wb_valid, wb_reg, wb_data,
           kill_valid, kill_reg,
    input  rd_data, rd_busy, stall, issue_ready, err
  );

  modport slave (
    input  rd_num, rd_use, issue_valid, issue_reg, wb_valid, wb_reg, wb_data,
           kill_valid, kill_reg,
    output rd_data, rd_busy, stall, issue_ready, err
  );

endinterface

// File: rtl/regfile_scoreboard_pend_ctr.sv
// Per-register pending-write counters: issue increments, WB and squash decrement,
// busy lookup per read port, sticky error on underflow or issue while full.
module rf_pend_ctr
  import rf_pkg::*;
#(
  parameter int unsigned NREGS = NREGS_DEF,
  parameter int unsigned NRD   = 2,
  parameter int unsigned NKILL = 2,
  parameter int unsigned CW    = CW_DEF,
  parameter int unsigned AW    = rf_aw(NREGS)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NRD*AW-1:0] rd_num,
  output logic [NRD-1:0]    rd_busy,
  input  logic              issue_valid,
  input  logic [AW-1:0]     issue_reg,
  output logic              issue_ready,
  input  logic              wb_valid,
  input  logic [AW-1:0]     wb_reg,
  input  logic [NKILL-1:0]  kill_valid,
  input  logic [NKILL*AW-1:0] kill_reg,
  output logic              err
);

  logic [NREGS-1:0][CW-1:0] r_cnt;
  logic [NREGS-1:0][CW-1:0] w_next;
  logic                     r_err;
  logic                     w_uflow;
  logic                     w_issue_ok;
  logic [31:0]              w_sum;
  logic [31:0]              w_dec;
  logic [AW-1:0]            w_n;
  logic                     w_hit;

  assign issue_ready = (issue_reg == AW'(ZERO_REG)) || (r_cnt[issue_reg] != '1);
  assign w_issue_ok  = issue_valid && issue_ready;
  assign err         = r_err;

  // All events on a register are summed into one signed delta; a deficit clamps to 0.
  always_comb begin
    w_next  = '0;
    w_uflow = 1'b0;
    w_sum   = '0;
    w_dec   = '0;
    for (int unsigned r = 1; r < NREGS; r++) begin
      w_sum = 32'(r_cnt[r]) + ((w_issue_ok && issue_reg == AW'(r)) ? 32'd1 : 32'd0);
      w_dec = (wb_valid && wb_reg == AW'(r)) ? 32'd1 : 32'd0;
      for (int unsigned j = 0; j < NKILL; j++) begin
        if (kill_valid[j] && kill_reg[j*AW +: AW] == AW'(r)) w_dec = w_dec + 32'd1;
      end
      if (w_dec > w_sum) begin
        w_next[r] = '0;
        w_uflow   = 1'b1;
      end else begin
        w_next[r] = CW'(w_sum - w_dec);
      end
    end
  end

  // A write retiring this cycle is covered by the bypass, so it does not count as busy.
  always_comb begin
    rd_busy = '0;
    w_n     = '0;
    w_hit   = 1'b0;
    for (int unsigned i = 0; i < NRD; i++) begin
      w_n        = rd_num[i*AW +: AW];
      w_hit      = wb_valid && (wb_reg == w_n);
      rd_busy[i] = (w_n != AW'(ZERO_REG)) && ((r_cnt[w_n] - CW'(w_hit)) != '0);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      r_cnt <= w_next;
      r_err <= r_err | w_uflow | (issue_valid & ~issue_ready);
    end
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// ID-stage register file with WB-to-ID bypass and write-pending scoreboard
// producing the operand hazard stall.
module regfile_scoreboard
  import rf_pkg::*;
#(
  parameter int unsigned XLEN  = XLEN_DEF,
  parameter int unsigned NREGS = NREGS_DEF,
  parameter int unsigned NRD   = 2,
  parameter int unsigned NKILL = 2,
  parameter int unsigned CW    = CW_DEF
) (
  input logic                 clock,
  input logic                 reset,
  regfile_scoreboard_if.slave bus
);

  localparam int unsigned AW = rf_aw(NREGS);

  logic [XLEN-1:0]     r_mem [1:NREGS-1];
  logic [NRD-1:0]      w_busy;
  logic [NRD*XLEN-1:0] w_rd_data;
  logic [AW-1:0]       w_n;

  rf_pend_ctr #(
    .NREGS (NREGS),
    .NRD   (NRD),
    .NKILL (NKILL),
    .CW    (CW),
    .AW    (AW)
  ) u_pend (
    .clock       (clock),
    .reset       (reset),
    .rd_num      (bus.rd_num),
    .rd_busy     (w_busy),
    .issue_valid (bus.issue_valid),
    .issue_reg   (bus.issue_reg),
    .issue_ready (bus.issue_ready),
    .wb_valid    (bus.wb_valid),
    .wb_reg      (bus.wb_reg),
    .kill_valid  (bus.kill_valid),
    .kill_reg    (bus.kill_reg),
    .err         (bus.err)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 1; i < NREGS; i++) r_mem[i] <= '0;
    end else if (bus.wb_valid && bus.wb_reg != AW'(ZERO_REG)) begin
      r_mem[bus.wb_reg] <= bus.wb_data;
    end
  end

  always_comb begin
    w_rd_data = '0;
    w_n       = '0;
    for (int unsigned i = 0; i < NRD; i++) begin
      w_n = bus.rd_num[i*AW +: AW];
      if (w_n == AW'(ZERO_REG))
        w_rd_data[i*XLEN +: XLEN] = '0;
      else if (bus.wb_valid && bus.wb_reg == w_n)
        w_rd_data[i*XLEN +: XLEN] = bus.wb_data;
      else
        w_rd_data[i*XLEN +: XLEN] = r_mem[w_n];
    end
  end

  assign bus.rd_data = w_rd_data;
  assign bus.rd_busy = w_busy;
  assign bus.stall   = |(bus.rd_use & w_busy);

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: reset, bypass, busy/stall, saturation,
// squash repair, simultaneous events and reset over in-flight work.
module tb_regfile_scoreboard;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned NREGS = 32;
  localparam int unsigned NRD   = 2;
  localparam int unsigned NKILL = 2;
  localparam int unsigned CW    = 2;
  localparam int unsigned AW    = 5;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clock = ~clock;

  regfile_scoreboard_if #(
    .XLEN (XLEN), .NREGS (NREGS), .NRD (NRD), .NKILL (NKILL), .AW (AW)
  ) bus ();

  regfile_scoreboard #(
    .XLEN (XLEN), .NREGS (NREGS), .NRD (NRD), .NKILL (NKILL), .CW (CW)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    bus.rd_num      = '0;
    bus.rd_use      = '0;
    bus.issue_valid = 1'b0;
    bus.issue_reg   = '0;
    bus.wb_valid    = 1'b0;
    bus.wb_reg      = '0;
    bus.wb_data     = '0;
    bus.kill_valid  = '0;
    bus.kill_reg    = '0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    bus.rd_use = 2'b11;
    for (int r = 0; r < 32; r++) begin
      bus.rd_num    = {5'(r), 5'(r)};
      bus.issue_reg = 5'(r);
      #1;
      n_checks++;
      if (bus.rd_data !== 64'h0 || bus.rd_busy !== 2'b00 || bus.stall !== 1'b0 ||
          bus.issue_ready !== 1'b1 || bus.err !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_r%0d data=%h busy=%b stall=%b ready=%b err=%b exp 0/00/0/1/0",
                 r, bus.rd_data, bus.rd_busy, bus.stall, bus.issue_ready, bus.err);
      end
    end
    idle();
  endtask

  task automatic test_bypass();
    bus.issue_valid = 1'b1;
    bus.issue_reg   = 5'd5;
    tick();
    idle();
    bus.wb_valid   = 1'b1;
    bus.wb_reg     = 5'd5;
    bus.wb_data    = 32'hDEADBEEF;
    bus.rd_num[4:0] = 5'd5;
    #1;
    n_checks++;
    if (bus.rd_data[31:0] !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL bypass_same_cycle got %h exp deadbeef", bus.rd_data[31:0]);
    end
    tick();
    bus.wb_valid = 1'b0;
    #1;
    n_checks++;
    if (bus.rd_data[31:0] !== 32'hDEADBEEF || bus.rd_busy[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL array_after_wb got %h busy=%b exp deadbeef busy=0",
               bus.rd_data[31:0], bus.rd_busy[0]);
    end
    bus.wb_valid    = 1'b1;
    bus.wb_reg      = 5'd0;
    bus.wb_data     = 32'h1234;
    bus.rd_num[4:0] = 5'd0;
    #1;
    n_checks++;
    if (bus.rd_data[31:0] !== 32'h0) begin
      n_fail++;
      $display("FAIL r0_bypass got %h exp 0", bus.rd_data[31:0]);
    end
    tick();
    bus.wb_valid = 1'b0;
    #1;
    n_checks++;
    if (bus.rd_data[31:0] !== 32'h0 || bus.err !== 1'b0) begin
      n_fail++;
      $display("FAIL r0_write got %h err=%b exp 0 err=0", bus.rd_data[31:0], bus.err);
    end
    idle();
  endtask

  task automatic test_busy_stall();
    bus.issue_valid = 1'b1;
    bus.issue_reg   = 5'd7;
    tick();
    idle();
    bus.rd_num[9:5] = 5'd7;
    bus.rd_use      = 2'b10;
    #1;
    n_checks++;
    if (bus.rd_busy !== 2'b10 || bus.stall !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_after_issue busy=%b stall=%b exp 10/1", bus.rd_busy, bus.stall);
    end
    bus.rd_use = 2'b00;
    #1;
    n_checks++;
    if (bus.stall !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_unused got %b exp 0", bus.stall);
    end
    bus.rd_use   = 2'b10;
    bus.wb_valid = 1'b1;
    bus.wb_reg   = 5'd7;
    bus.wb_data  = 32'h55;
    #1;
    n_checks++;
    if (bus.rd_busy[1] !== 1'b0 || bus.stall !== 1'b0 || bus.rd_data[63:32] !== 32'h55) begin
      n_fail++;
      $display("FAIL wb_clears_busy busy=%b stall=%b data=%h exp 0/0/55",
               bus.rd_busy[1], bus.stall, bus.rd_data[63:32]);
    end
    tick();
    bus.wb_valid = 1'b0;
    #1;
    n_checks++;
    if (bus.rd_busy[1] !== 1'b0 || bus.rd_data[63:32] !== 32'h55 || bus.err !== 1'b0) begin
      n_fail++;
      $display("FAIL count_zero busy=%b data=%h err=%b exp 0/55/0",
               bus.rd_busy[1], bus.rd_data[63:32], bus.err);
    end
    idle();
  endtask

  task automatic test_saturate();
    bus.issue_reg = 5'd3;
    for (int k = 0; k < 3; k++) begin
      bus.issue_valid = 1'b0;
      #1;
      n_checks++;
      if (bus.issue_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL ready_before_issue%0d got %b exp 1", k, bus.issue_ready);
      end
      bus.issue_valid = 1'b1;
      tick();
    end
    bus.issue_valid = 1'b0;
    #1;
    n_checks++;
    if (bus.issue_ready !== 1'b0 || bus.err !== 1'b0) begin
      n_fail++;
      $display("FAIL saturated ready=%b err=%b exp 0/0", bus.issue_ready, bus.err);
    end
    bus.issue_valid = 1'b1;
    tick();
    idle();
    bus.rd_num[4:0] = 5'd3;
    #1;
    n_checks++;
    if (bus.err !== 1'b1 || bus.rd_busy[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL dropped_issue err=%b busy=%b exp 1/1", bus.err, bus.rd_busy[0]);
    end
    // Remaining counts after each retire: 2, 1, 0.
    for (int k = 0; k < 3; k++) begin
      bus.wb_valid = 1'b1;
      bus.wb_reg   = 5'd3;
      bus.wb_data  = 32'(k);
      tick();
      bus.wb_valid = 1'b0;
      #1;
      n_checks++;
      if (bus.rd_busy[0] !== (k < 2)) begin
        n_fail++;
        $display("FAIL drain_wb%0d busy=%b exp %b", k, bus.rd_busy[0], (k < 2));
      end
    end
    bus.issue_reg = 5'd3;
    #1;
    n_checks++;
    if (bus.issue_ready !== 1'b1 || bus.rd_data[31:0] !== 32'd2) begin
      n_fail++;
      $display("FAIL drained ready=%b data=%h exp 1/2", bus.issue_ready, bus.rd_data[31:0]);
    end
    idle();
  endtask

  task automatic test_kill();
    do_reset();
    bus.issue_valid = 1'b1;
    bus.issue_reg   = 5'd9;
    tick();
    tick();
    idle();
    bus.rd_num[4:0] = 5'd9;
    #1;
    n_checks++;
    if (bus.rd_busy[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_before_kill got %b exp 1", bus.rd_busy[0]);
    end
    bus.kill_valid = 2'b11;
    bus.kill_reg   = {5'd9, 5'd9};
    tick();
    bus.kill_valid = 2'b00;
    #1;
    n_checks++;
    if (bus.rd_busy[0] !== 1'b0 || bus.err !== 1'b0) begin
      n_fail++;
      $display("FAIL double_kill busy=%b err=%b exp 0/0", bus.rd_busy[0], bus.err);
    end
    bus.kill_valid = 2'b01;
    bus.kill_reg   = {5'd0, 5'd9};
    tick();
    bus.kill_valid = 2'b00;
    bus.issue_reg  = 5'd9;
    #1;
    n_checks++;
    if (bus.err !== 1'b1 || bus.rd_busy[0] !== 1'b0 || bus.issue_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL kill_underflow err=%b busy=%b ready=%b exp 1/0/1",
               bus.err, bus.rd_busy[0], bus.issue_ready);
    end
    idle();
  endtask

  task automatic test_simultaneous();
    do_reset();
    bus.issue_valid = 1'b1;
    bus.issue_reg   = 5'd6;
    tick();
    bus.wb_valid = 1'b1;
    bus.wb_reg   = 5'd6;
    tick();
    bus.wb_valid = 1'b0;
    bus.issue_valid = 1'b0;
    bus.rd_num[4:0] = 5'd6;
    #1;
    n_checks++;
    if (bus.rd_busy[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL issue_plus_wb busy=%b exp 1", bus.rd_busy[0]);
    end
    bus.issue_valid = 1'b1;
    bus.kill_valid  = 2'b10;
    bus.kill_reg    = {5'd6, 5'd0};
    tick();
    bus.issue_valid = 1'b0;
    bus.kill_valid  = 2'b00;
    #1;
    n_checks++;
    if (bus.rd_busy[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL issue_plus_kill busy=%b exp 1", bus.rd_busy[0]);
    end
    bus.issue_valid = 1'b1;
    bus.wb_valid    = 1'b1;
    bus.kill_valid  = 2'b01;
    bus.kill_reg    = {5'd0, 5'd6};
    tick();
    idle();
    bus.rd_num[4:0] = 5'd6;
    #1;
    n_checks++;
    if (bus.rd_busy[0] !== 1'b0 || bus.err !== 1'b0) begin
      n_fail++;
      $display("FAIL issue_wb_kill busy=%b err=%b exp 0/0", bus.rd_busy[0], bus.err);
    end
    idle();
  endtask

  task automatic test_reset_inflight();
    bus.issue_valid = 1'b1;
    bus.issue_reg   = 5'd4;
    bus.wb_valid    = 1'b1;
    bus.wb_reg      = 5'd10;
    bus.wb_data     = 32'hAA;
    tick();
    reset         = 1'b1;
    bus.wb_reg    = 5'd11;
    bus.wb_data   = 32'hBB;
    tick();
    reset = 1'b0;
    idle();
    bus.rd_num    = {5'd10, 5'd4};
    bus.rd_use    = 2'b11;
    bus.issue_reg = 5'd4;
    #1;
    n_checks++;
    if (bus.rd_busy !== 2'b00 || bus.stall !== 1'b0 || bus.rd_data !== 64'h0 ||
        bus.err !== 1'b0 || bus.issue_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_inflight busy=%b stall=%b data=%h err=%b ready=%b exp 00/0/0/0/1",
               bus.rd_busy, bus.stall, bus.rd_data, bus.err, bus.issue_ready);
    end
    bus.rd_num = {5'd11, 5'd11};
    #1;
    n_checks++;
    if (bus.rd_data !== 64'h0) begin
      n_fail++;
      $display("FAIL reset_beats_wb got %h exp 0", bus.rd_data);
    end
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_bypass();
    test_busy_stall();
    test_saturate();
    test_kill();
    test_simultaneous();
    test_reset_inflight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

endmodule
